// File: rtl/gb_debug_pkg.sv
// Shared definitions for the Game Boy debug step controller: FSM state
// encoding, debug command bytes and the default tick count per step.
// The BREAKPOINT_EN macro adds the breakpoint address argument states.
package gb_debug_pkg;

  // One machine cycle is four T-states of the GB clock
  localparam int TICKS_PER_STEP_DEF = 4;

  localparam logic [7:0] CMD_HALT  = 8'h68;  // 'h'
  localparam logic [7:0] CMD_RUN   = 8'h72;  // 'r'
  localparam logic [7:0] CMD_STEP  = 8'h73;  // 's'
  localparam logic [7:0] CMD_NSTEP = 8'h6E;  // 'n'
  localparam logic [7:0] CMD_BP    = 8'h62;  // 'b'
  localparam logic [7:0] CMD_BPCLR = 8'h63;  // 'c'

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_HALTED = 3'd1,
    ST_STEP   = 3'd2,
`ifdef BREAKPOINT_EN
    ST_ARG_N  = 3'd3,
    ST_ARG_LO = 3'd4,
    ST_ARG_HI = 3'd5
`else
    ST_ARG_N  = 3'd3
`endif
  } state_t;

  // Tick counter width: enough for COUNT_W steps of TICKS_PER_STEP ticks
  function automatic int tick_cnt_w(input int count_w, input int ticks_per_step);
    return count_w + $clog2(ticks_per_step);
  endfunction

endpackage

// File: rtl/debug_step_controller_step_counter.sv
// step_counter: counts gb_tick strobes while running and flags the tick that
// completes N steps. done is combinational on that tick so the owner can
// register its reaction on the same edge the final tick is seen.
module step_counter
  import gb_debug_pkg::*;
#(
  parameter int TICKS_PER_STEP = TICKS_PER_STEP_DEF,
  parameter int COUNT_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [COUNT_W-1:0] count_n,
  input  logic               run,
  input  logic               tick,
  output logic               done
);

  localparam int CW = tick_cnt_w(COUNT_W, TICKS_PER_STEP);

  logic [CW-1:0] tick_cnt;
  logic [CW-1:0] tick_target;

  // Load clears the count and latches the total tick target; otherwise count ticks while running
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt    <= '0;
      tick_target <= '0;
    end else if (load) begin
      tick_cnt    <= '0;
      tick_target <= CW'(count_n) * CW'(TICKS_PER_STEP);
    end else if (run && tick) begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  assign done = run && tick && (tick_cnt == tick_target - 1'b1);

endmodule

// File: rtl/debug_step_controller.sv
// debug_step_controller: decodes UART debug bytes and sequences the GB core
// between run, halt and counted single-step. All outputs are registered; a
// byte seen in cycle k acts at edge k+1, with trigger marking halt_req edges.
// Optional feature macro: BREAKPOINT_EN (PC breakpoint checked in RUN).
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_RUN    | core free-running, halt_req = 0
// ST_HALTED | core halted, waiting for a command
// ST_STEP   | core released for N*TICKS_PER_STEP gb_ticks
// ST_ARG_N  | next byte is the step count N (not decoded)
// ST_ARG_LO | next byte is breakpoint address low byte
// ST_ARG_HI | next byte is breakpoint address high byte
module debug_step_controller
  import gb_debug_pkg::*;
#(
  parameter int TICKS_PER_STEP = TICKS_PER_STEP_DEF,
  parameter int COUNT_W        = 8,
  parameter bit START_HALTED   = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_byte,
  input  logic        gb_tick,
  input  logic [15:0] pc,
  output logic        halt_req,
  output logic        trigger,
  output logic        step_busy,
  output logic        cmd_error,
  output logic        bp_hit
);

  state_t             state;
  logic               step_load;
  logic [COUNT_W-1:0] step_n;
  logic [COUNT_W-1:0] arg_n;
  logic               step_done;
  logic               bp_match;
  logic               rx_halt;

  assign arg_n   = COUNT_W'(rx_byte);
  assign rx_halt = rx_valid && (rx_byte == CMD_HALT);

`ifdef BREAKPOINT_EN
  logic        bp_armed;
  logic [15:0] bp_addr;
  logic [7:0]  bp_lo;

  assign bp_match = bp_armed && gb_tick && (pc == bp_addr);
`else
  logic unused_pc;

  assign unused_pc = ^pc;
  assign bp_match  = 1'b0;
  assign bp_hit    = 1'b0;
`endif

  // Every STEP entry reloads the counter, so a fresh step never sees stale ticks
  always_comb begin
    step_load = 1'b0;
    step_n    = '0;
    if (rx_valid) begin
      if (state == ST_HALTED && rx_byte == CMD_STEP) begin
        step_load = 1'b1;
        step_n    = COUNT_W'(1);
      end else if (state == ST_ARG_N && arg_n != '0) begin
        step_load = 1'b1;
        step_n    = arg_n;
      end
    end
  end

  step_counter #(
    .TICKS_PER_STEP(TICKS_PER_STEP),
    .COUNT_W       (COUNT_W)
  ) u_step_counter (
    .clk    (clk),
    .reset  (reset),
    .load   (step_load),
    .count_n(step_n),
    .run    (state == ST_STEP),
    .tick   (gb_tick),
    .done   (step_done)
  );

  // Command FSM with registered outputs; trigger is set only where halt_req actually flips
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= START_HALTED ? ST_HALTED : ST_RUN;
      halt_req  <= START_HALTED;
      trigger   <= 1'b0;
      step_busy <= 1'b0;
      cmd_error <= 1'b0;
`ifdef BREAKPOINT_EN
      bp_hit    <= 1'b0;
      bp_armed  <= 1'b0;
      bp_addr   <= '0;
      bp_lo     <= '0;
`endif
    end else begin
      trigger   <= 1'b0;
      cmd_error <= 1'b0;
`ifdef BREAKPOINT_EN
      bp_hit    <= 1'b0;
`endif
      case (state)
        ST_RUN: begin
          // A breakpoint hit absorbs a coincident 'h' into the same single transition
          if (bp_match || rx_halt) begin
            state    <= ST_HALTED;
            halt_req <= 1'b1;
            trigger  <= 1'b1;
          end
`ifdef BREAKPOINT_EN
          bp_hit <= bp_match;
`endif
          if (rx_valid && rx_byte != CMD_HALT && rx_byte != CMD_RUN) cmd_error <= 1'b1;
        end
        ST_HALTED: begin
          if (rx_valid) begin
            case (rx_byte)
              CMD_RUN: begin
                state    <= ST_RUN;
                halt_req <= 1'b0;
                trigger  <= 1'b1;
              end
              CMD_STEP: begin
                state     <= ST_STEP;
                halt_req  <= 1'b0;
                trigger   <= 1'b1;
                step_busy <= 1'b1;
              end
              CMD_NSTEP: state <= ST_ARG_N;
              CMD_HALT:  ;
`ifdef BREAKPOINT_EN
              CMD_BP:    state <= ST_ARG_LO;
              CMD_BPCLR: bp_armed <= 1'b0;
`endif
              default:   cmd_error <= 1'b1;
            endcase
          end
        end
        ST_ARG_N: begin
          if (rx_valid) begin
            if (arg_n != '0) begin
              state     <= ST_STEP;
              halt_req  <= 1'b0;
              trigger   <= 1'b1;
              step_busy <= 1'b1;
            end else begin
              state <= ST_HALTED;
            end
          end
        end
        ST_STEP: begin
          // Final tick and 'h' in the same cycle collapse into one halt
          if (step_done || rx_halt) begin
            state     <= ST_HALTED;
            halt_req  <= 1'b1;
            trigger   <= 1'b1;
            step_busy <= 1'b0;
          end
          if (rx_valid && rx_byte != CMD_HALT) cmd_error <= 1'b1;
        end
`ifdef BREAKPOINT_EN
        ST_ARG_LO: begin
          if (rx_valid) begin
            bp_lo <= rx_byte;
            state <= ST_ARG_HI;
          end
        end
        ST_ARG_HI: begin
          if (rx_valid) begin
            bp_addr  <= {rx_byte, bp_lo};
            bp_armed <= 1'b1;
            state    <= ST_HALTED;
          end
        end
`endif
        default: begin
          state     <= ST_HALTED;
          halt_req  <= 1'b1;
          trigger   <= !halt_req;
          step_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_debug_step_controller.sv
// Directed bench for debug_step_controller (default parameters: 4 ticks per
// step, START_HALTED=1). Breakpoint checks follow the BREAKPOINT_EN macro.
module tb_debug_step_controller;
  import gb_debug_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_byte;
  logic        gb_tick;
  logic [15:0] pc;
  logic        halt_req, trigger, step_busy, cmd_error, bp_hit;

  int n_cmp = 0;
  int n_bad = 0;
  int trig_cnt = 0;
  int t0;

  always #5 clk = ~clk;

  debug_step_controller dut (
    .clk      (clk),
    .reset    (reset),
    .rx_valid (rx_valid),
    .rx_byte  (rx_byte),
    .gb_tick  (gb_tick),
    .pc       (pc),
    .halt_req (halt_req),
    .trigger  (trigger),
    .step_busy(step_busy),
    .cmd_error(cmd_error),
    .bp_hit   (bp_hit)
  );

  always @(negedge clk) if (trigger) trig_cnt++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; returns 1 time unit after the edge
  task automatic cyc(input logic v, input logic [7:0] b, input logic t);
    rx_valid = v;
    rx_byte  = b;
    gb_tick  = t;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
    gb_tick  = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 8'h00, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    reset = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; gb_tick = 1'b0; pc = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    chk("rst_halt", halt_req, 1);
    chk("rst_trig", trigger, 0);
    chk("rst_busy", step_busy, 0);
    chk("rst_err", cmd_error, 0);
    chk("rst_bp", bp_hit, 0);

    // run / halt
    t0 = trig_cnt;
    send(CMD_RUN);
    chk("r_halt", halt_req, 0);
    chk("r_trig", trigger, 1);
    idle();
    chk("r_trig_off", trigger, 0);
    send(CMD_RUN);
    chk("r_noop_halt", halt_req, 0);
    chk("r_noop_trig", trigger, 0);
    send(CMD_HALT);
    chk("h_halt", halt_req, 1);
    chk("h_trig", trigger, 1);
    idle();
    chk("rh_trig_cnt", trig_cnt - t0, 2);

    // single step
    t0 = trig_cnt;
    send(CMD_STEP);
    chk("s_busy", step_busy, 1);
    chk("s_halt", halt_req, 0);
    chk("s_trig", trigger, 1);
    for (int i = 0; i < 4; i++) begin
      chk("s_busy_tick", step_busy, 1);
      ticks(1);
      if (i < 3) chk("s_mid_halt", halt_req, 0);
    end
    chk("s_end_halt", halt_req, 1);
    chk("s_end_trig", trigger, 1);
    chk("s_end_busy", step_busy, 0);
    idle();
    chk("s_trig_cnt", trig_cnt - t0, 2);

    // N = 3
    t0 = trig_cnt;
    send(CMD_NSTEP);
    chk("n_arg_halt", halt_req, 1);
    chk("n_arg_trig", trigger, 0);
    send(8'h03);
    chk("n3_busy", step_busy, 1);
    ticks(11);
    chk("n3_11_halt", halt_req, 0);
    ticks(1);
    chk("n3_12_halt", halt_req, 1);
    chk("n3_12_trig", trigger, 1);
    idle();
    chk("n3_trig_cnt", trig_cnt - t0, 2);

    // N = 0
    t0 = trig_cnt;
    send(CMD_NSTEP);
    send(8'h00);
    chk("n0_halt", halt_req, 1);
    chk("n0_busy", step_busy, 0);
    chk("n0_err", cmd_error, 0);
    idle();
    chk("n0_trig_cnt", trig_cnt - t0, 0);

    // N = 0x68 ('h' as argument): 416 ticks
    t0 = trig_cnt;
    send(CMD_NSTEP);
    send(8'h68);
    chk("n68_busy", step_busy, 1);
    ticks(415);
    chk("n68_415_busy", step_busy, 1);
    chk("n68_415_halt", halt_req, 0);
    ticks(1);
    chk("n68_halt", halt_req, 1);
    chk("n68_busy_end", step_busy, 0);
    idle();
    chk("n68_trig_cnt", trig_cnt - t0, 2);

    // abort after 5 of 8 ticks
    t0 = trig_cnt;
    send(CMD_NSTEP);
    send(8'h02);
    ticks(5);
    send(CMD_HALT);
    chk("ab_halt", halt_req, 1);
    chk("ab_trig", trigger, 1);
    chk("ab_busy", step_busy, 0);
    ticks(4);
    chk("ab_after_halt", halt_req, 1);
    chk("ab_trig_cnt", trig_cnt - t0, 2);

    // illegal byte mid-step, then 'h' coincident with the 8th tick
    t0 = trig_cnt;
    send(CMD_NSTEP);
    send(8'h02);
    ticks(3);
    send(CMD_RUN);
    chk("st_err", cmd_error, 1);
    chk("st_err_busy", step_busy, 1);
    ticks(4);
    chk("co_pre_halt", halt_req, 0);
    cyc(1'b1, CMD_HALT, 1'b1);
    chk("co_halt", halt_req, 1);
    chk("co_trig", trigger, 1);
    chk("co_busy", step_busy, 0);
    chk("co_err", cmd_error, 0);
    idle();
    idle();
    chk("co_trig_cnt", trig_cnt - t0, 2);

    // illegal bytes
    send(8'h78);
    chk("x_err", cmd_error, 1);
    chk("x_halt", halt_req, 1);
    chk("x_trig", trigger, 0);
    idle();
    chk("x_err_off", cmd_error, 0);
    send(CMD_RUN);
    send(CMD_STEP);
    chk("run_s_err", cmd_error, 1);
    chk("run_s_halt", halt_req, 0);
    chk("run_s_busy", step_busy, 0);
    send(CMD_NSTEP);
    chk("run_n_err", cmd_error, 1);
    send(CMD_HALT);
    chk("run_h_halt", halt_req, 1);

    // reset mid-ARG_N: next byte is a command again
    send(CMD_NSTEP);
    reset = 1'b1;
    idle();
    chk("rarg_halt", halt_req, 1);
    chk("rarg_trig", trigger, 0);
    reset = 1'b0;
    send(CMD_RUN);
    chk("rarg_r_halt", halt_req, 0);
    chk("rarg_r_busy", step_busy, 0);
    send(CMD_HALT);

    // reset mid-STEP
    send(CMD_STEP);
    ticks(1);
    reset = 1'b1;
    idle();
    chk("rstep_halt", halt_req, 1);
    chk("rstep_busy", step_busy, 0);
    chk("rstep_trig", trigger, 0);
    reset = 1'b0;
    ticks(4);
    chk("rstep_after", halt_req, 1);

`ifdef BREAKPOINT_EN
    send(CMD_BP);
    send(8'h50);
    send(8'h01);
    chk("bp_load_halt", halt_req, 1);
    chk("bp_load_err", cmd_error, 0);
    send(CMD_RUN);
    pc = 16'h0150;
    idle();
    chk("bp_notick", halt_req, 0);
    pc = 16'h014F;
    ticks(1);
    chk("bp_miss", halt_req, 0);
    chk("bp_miss_hit", bp_hit, 0);
    pc = 16'h0150;
    cyc(1'b1, CMD_HALT, 1'b1);
    chk("bp_halt", halt_req, 1);
    chk("bp_trig", trigger, 1);
    chk("bp_hit", bp_hit, 1);
    idle();
    chk("bp_hit_off", bp_hit, 0);
    send(CMD_BPCLR);
    send(CMD_RUN);
    ticks(1);
    chk("bp_clr", halt_req, 0);
    send(CMD_HALT);
`else
    send(CMD_BP);
    chk("nobp_b_err", cmd_error, 1);
    send(CMD_BPCLR);
    chk("nobp_c_err", cmd_error, 1);
    send(CMD_RUN);
    pc = 16'h0150;
    ticks(1);
    chk("nobp_run", halt_req, 0);
    chk("nobp_hit", bp_hit, 0);
    send(CMD_HALT);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
